sa_autosa_sdp_rdma_rdarb: RTL

SA_AUTOSA_SDP_RDMA_RDARB -- requirements
Module: sa_autosa_sdp_rdma_rdarb

---
 rtl/sa_autosa_sdp_rdma_rdarb.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sa_autosa_sdp_rdma_rdarb.sv
`default_nettype none
// sa_autosa_sdp_rdma_rdarb: 3-way round-robin DMA read arbiter with latency-FIFO
// credit tracking and a tag FIFO that steers read responses back to their requester.
module sa_autosa_sdp_rdma_rdarb #(
  parameter int LAT_DEPTH = 256,
  parameter int TAG_DEPTH = 8
) (
  input  logic         autosa_core_clk,
  input  logic         autosa_core_rstn,
  input  logic         cfg_en,
  input  logic [78:0]  req0_pd,
  input  logic         req0_vld,
  output logic         req0_rdy,
  input  logic [78:0]  req1_pd,
  input  logic         req1_vld,
  output logic         req1_rdy,
  input  logic [78:0]  req2_pd,
  input  logic         req2_vld,
  output logic         req2_rdy,
  output logic [256:0] rsp0_pd,
  output logic         rsp0_vld,
  input  logic         rsp0_rdy,
  output logic [256:0] rsp1_pd,
  output logic         rsp1_vld,
  input  logic         rsp1_rdy,
  output logic [256:0] rsp2_pd,
  output logic         rsp2_vld,
  input  logic         rsp2_rdy,
  output logic [78:0]  dma_rd_req_pd,
  output logic         dma_rd_req_vld,
  input  logic         dma_rd_req_rdy,
  input  logic [256:0] dma_rd_rsp_pd,
  input  logic         dma_rd_rsp_vld,
  output logic         dma_rd_rsp_rdy,
  input  logic         lat_fifo_pop,
  output logic         dma_rd_cdt_lat_fifo_pop,
  output logic         idle,
  output logic         rsp_err,
  output logic [8:0]   credits
);

  localparam int TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int TAG_CW = $clog2(TAG_DEPTH + 1);
  localparam logic [8:0] CRED_MAX = 9'(LAT_DEPTH);

  wire clk   = autosa_core_clk;
  wire rst_n = autosa_core_rstn;

  logic [78:0] req_pd [3];
  logic [2:0]  req_vld;
  logic [15:0] cost [3];
  logic [2:0]  elig;
  logic [2:0]  grant;
  logic        win;
  logic [1:0]  win_id;
  logic [78:0] win_pd;
  logic [8:0]  win_cost;
  logic [1:0]  rr_ptr;

  logic [16:0]       tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0] tag_wr;
  logic [TAG_AW-1:0] tag_rd;
  logic [TAG_CW-1:0] tag_cnt;
  logic              tag_empty;
  logic              tag_full;
  logic              tag_pop;
  logic [16:0]       head;
  logic [1:0]        head_id;
  logic [14:0]       head_size;
  logic [14:0]       beat_cnt;
  logic              route_rdy;
  logic              rsp_acc;
  logic              out_free;
  logic              pop_ok;

  assign req_pd[0] = req0_pd;
  assign req_pd[1] = req1_pd;
  assign req_pd[2] = req2_pd;
  assign req_vld   = {req2_vld, req1_vld, req0_vld};

  function automatic logic [1:0] rr_idx(input logic [1:0] ptr, input int k);
    logic [2:0] s;
    s = {1'b0, ptr} + 3'(k);
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [TAG_AW-1:0] ptr_inc(input logic [TAG_AW-1:0] p);
    return (p == TAG_AW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Tag FIFO head and response steering
  assign tag_empty = (tag_cnt == '0);
  assign head      = tag_mem[tag_rd];
  assign head_id   = head[16:15];
  assign head_size = head[14:0];

  always_comb begin
    route_rdy = 1'b1;
    case (head_id)
      2'd0:    route_rdy = rsp0_rdy;
      2'd1:    route_rdy = rsp1_rdy;
      2'd2:    route_rdy = rsp2_rdy;
      default: route_rdy = 1'b1;
    endcase
  end

  assign dma_rd_rsp_rdy = tag_empty ? 1'b1 : route_rdy;
  assign rsp_acc  = dma_rd_rsp_vld && dma_rd_rsp_rdy && !tag_empty;
  assign tag_pop  = rsp_acc && (beat_cnt == head_size);
  // A completing response frees its slot in time for a grant in the same cycle.
  assign tag_full = (tag_cnt == TAG_CW'(TAG_DEPTH)) && !tag_pop;

  assign rsp0_pd  = dma_rd_rsp_pd;
  assign rsp1_pd  = dma_rd_rsp_pd;
  assign rsp2_pd  = dma_rd_rsp_pd;
  assign rsp0_vld = rst_n && dma_rd_rsp_vld && !tag_empty && (head_id == 2'd0);
  assign rsp1_vld = rst_n && dma_rd_rsp_vld && !tag_empty && (head_id == 2'd1);
  assign rsp2_vld = rst_n && dma_rd_rsp_vld && !tag_empty && (head_id == 2'd2);

  assign out_free = !dma_rd_req_vld || dma_rd_req_rdy;

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      cost[n] = {1'b0, req_pd[n][78:64]} + 16'd1;
      elig[n] = req_vld[n] && cfg_en && ({7'd0, credits} >= cost[n]) && !tag_full && out_free;
    end
  end

  // Round-robin search begins at rr_ptr, the requester after the last winner.
  always_comb begin
    win      = 1'b0;
    win_id   = 2'd0;
    win_pd   = '0;
    win_cost = '0;
    for (int k = 0; k < 3; k++) begin
      if (!win && elig[rr_idx(rr_ptr, k)]) begin
        win      = 1'b1;
        win_id   = rr_idx(rr_ptr, k);
        win_pd   = req_pd[rr_idx(rr_ptr, k)];
        win_cost = {1'b0, req_pd[rr_idx(rr_ptr, k)][71:64]} + 9'd1;
      end
    end
  end

  always_comb begin
    grant = 3'b000;
    if (win && rst_n) grant[win_id] = 1'b1;
  end

  assign req0_rdy = grant[0];
  assign req1_rdy = grant[1];
  assign req2_rdy = grant[2];

  assign pop_ok = lat_fifo_pop && (credits != CRED_MAX);
  assign idle   = !dma_rd_req_vld && tag_empty && (credits == CRED_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_rd_req_vld          <= 1'b0;
      dma_rd_req_pd           <= '0;
      rr_ptr                  <= 2'd0;
      credits                 <= CRED_MAX;
      rsp_err                 <= 1'b0;
      dma_rd_cdt_lat_fifo_pop <= 1'b0;
    end else begin
      if (win) begin
        dma_rd_req_vld <= 1'b1;
        dma_rd_req_pd  <= win_pd;
        rr_ptr         <= (win_id == 2'd2) ? 2'd0 : win_id + 2'd1;
      end else if (dma_rd_req_rdy) begin
        dma_rd_req_vld <= 1'b0;
      end
      // win_cost never exceeds credits, so the subtraction cannot wrap.
      credits <= credits - (win ? win_cost : 9'd0) + (pop_ok ? 9'd1 : 9'd0);
      if ((lat_fifo_pop && !pop_ok) || (dma_rd_rsp_vld && tag_empty)) rsp_err <= 1'b1;
      dma_rd_cdt_lat_fifo_pop <= lat_fifo_pop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr   <= '0;
      tag_rd   <= '0;
      tag_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      if (win) tag_wr <= ptr_inc(tag_wr);
      if (tag_pop) tag_rd <= ptr_inc(tag_rd);
      if (win && !tag_pop) tag_cnt <= tag_cnt + 1'b1;
      else if (!win && tag_pop) tag_cnt <= tag_cnt - 1'b1;
      if (tag_pop) beat_cnt <= '0;
      else if (rsp_acc) beat_cnt <= beat_cnt + 15'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (win) tag_mem[tag_wr] <= {win_id, win_pd[78:64]};
  end

endmodule
`default_nettype wire
